fc_frame_sequencer: RTL and testbench

- Frame-level controller in front of fully_connected.
- Gates the Pool2 3-channel stream into the FC through a valid/ready handshake and counts exactly INPUT_WIDTH beats per frame.
- Collects the OUTPUT_NUM sequential logits, tracks a running argmax, and presents {class, max logit} on a valid/ready result port.
- Holds off the next frame until the result is consumed, and flags timeouts and spurious logits.

---
 rtl/fc_ctrl_pkg.sv | 21 ++
 rtl/fc_argmax_tracker.sv | 43 ++++
 rtl/fc_frame_sequencer.sv | 204 ++++++++++++++++++++
 tb/tb_fc_frame_sequencer.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fc_ctrl_pkg.sv
// Shared types and defaults for the FC frame sequencer.
//   fc_state_e : frame sequencer states
//   DATA_W     : default sample/logit width
//   CLS_W      : class index width
//   *_DEF      : default beat count, logit count and logit-gap timeout
package fc_ctrl_pkg;

  localparam int unsigned DATA_W          = 12;
  localparam int unsigned CLS_W           = 4;
  localparam int unsigned INPUT_WIDTH_DEF = 16;
  localparam int unsigned OUTPUT_NUM_DEF  = 10;
  localparam int unsigned TIMEOUT_CYC_DEF = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FEED = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } fc_state_e;

endpackage

// File: rtl/fc_argmax_tracker.sv
// Running argmax over a strobed stream of signed logits.
//   clear_i  : zero index/value registers
//   strobe_i : a logit is present on data_i with its index on idx_i
//   load_i   : take this logit unconditionally (first of a frame)
//   idx_o    : index of the current maximum
//   val_o    : current maximum value
module fc_argmax_tracker
  import fc_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = fc_ctrl_pkg::DATA_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear_i,
  input  logic                     strobe_i,
  input  logic                     load_i,
  input  logic [CLS_W-1:0]         idx_i,
  input  logic signed [DATA_W-1:0] data_i,
  output logic [CLS_W-1:0]         idx_o,
  output logic signed [DATA_W-1:0] val_o
);

  logic [CLS_W-1:0]         idx_q;
  logic signed [DATA_W-1:0] val_q;

  // Strictly-greater replace keeps the lowest index on ties.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q <= '0;
      val_q <= '0;
    end else if (clear_i) begin
      idx_q <= '0;
      val_q <= '0;
    end else if (strobe_i && (load_i || (data_i > val_q))) begin
      idx_q <= idx_i;
      val_q <= data_i;
    end
  end

  assign idx_o = idx_q;
  assign val_o = val_q;

endmodule

// File: rtl/fc_frame_sequencer.sv
// Frame-level controller in front of fully_connected.
// Feeds INPUT_WIDTH 3-channel beats to the FC, collects OUTPUT_NUM logits,
// tracks their argmax and offers {class, max logit} on a valid/ready port.
//   s_valid/s_ready/s_data_*  : Pool2 beat input
//   fc_valid_in/fc_data_*     : registered beat to the FC (1 cycle latency)
//   fc_valid_out/fc_data_out  : logit strobe from the FC
//   m_valid/m_ready/m_class/m_logit : result port
//   busy, err_timeout, err_spurious : status (errors sticky until reset)
//   rd_idx/rd_data            : score buffer read (FC_SCORE_BUF_EN only,
//                               otherwise rd_data is 0)
module fc_frame_sequencer
  import fc_ctrl_pkg::*;
#(
  parameter int unsigned INPUT_WIDTH = INPUT_WIDTH_DEF,
  parameter int unsigned OUTPUT_NUM  = OUTPUT_NUM_DEF,
  parameter int unsigned DATA_W      = fc_ctrl_pkg::DATA_W,
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic signed [DATA_W-1:0] s_data_1,
  input  logic signed [DATA_W-1:0] s_data_2,
  input  logic signed [DATA_W-1:0] s_data_3,
  output logic                     fc_valid_in,
  output logic signed [DATA_W-1:0] fc_data_1,
  output logic signed [DATA_W-1:0] fc_data_2,
  output logic signed [DATA_W-1:0] fc_data_3,
  input  logic signed [DATA_W-1:0] fc_data_out,
  input  logic                     fc_valid_out,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [CLS_W-1:0]         m_class,
  output logic signed [DATA_W-1:0] m_logit,
  output logic                     busy,
  output logic                     err_timeout,
  output logic                     err_spurious,
  input  logic [CLS_W-1:0]         rd_idx,
  output logic signed [DATA_W-1:0] rd_data
);

  localparam int unsigned BEAT_W = (INPUT_WIDTH > 1) ? $clog2(INPUT_WIDTH) : 1;
  localparam int unsigned GAP_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  fc_state_e                state_q, state_d;
  logic [BEAT_W-1:0]        beat_q, beat_d;
  logic [CLS_W-1:0]         lg_q, lg_d;
  logic [GAP_W-1:0]         gap_q, gap_d;
  logic                     err_to_q, err_to_d;
  logic                     err_sp_q, err_sp_d;
  logic                     s_ready_q, busy_q, m_valid_q, fc_valid_q;
  logic signed [DATA_W-1:0] fc_d1_q, fc_d2_q, fc_d3_q;

  logic                     accept;
  logic                     logit_stb;
  logic                     trk_clear;
  logic                     trk_load;

  assign accept    = s_valid & s_ready_q;
  assign logit_stb = fc_valid_out & (state_q == WAIT);

  // Next-state and counter logic.
  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    lg_d      = lg_q;
    gap_d     = gap_q;
    err_to_d  = err_to_q;
    err_sp_d  = err_sp_q;
    trk_clear = 1'b0;
    trk_load  = 1'b0;

    case (state_q)
      IDLE: begin
        // Logit and gap counters start fresh on every WAIT entry.
        lg_d  = '0;
        gap_d = '0;
        if (accept) begin
          beat_d    = BEAT_W'(1);
          trk_clear = 1'b1;
          state_d   = (INPUT_WIDTH == 1) ? WAIT : FEED;
        end
      end
      FEED: begin
        lg_d  = '0;
        gap_d = '0;
        if (accept) begin
          beat_d = beat_q + 1'b1;
          if (beat_q == BEAT_W'(INPUT_WIDTH - 1)) begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (fc_valid_out) begin
          trk_load = (lg_q == '0);
          gap_d    = '0;
          lg_d     = lg_q + 1'b1;
          if (lg_q == CLS_W'(OUTPUT_NUM - 1)) begin
            state_d = DONE;
          end
        end else if (gap_q == GAP_W'(TIMEOUT_CYC - 1)) begin
          // This idle cycle brings the gap to TIMEOUT_CYC: abandon the frame.
          err_to_d = 1'b1;
          state_d  = IDLE;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      DONE: begin
        if (m_valid_q && m_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (fc_valid_out && (state_q != WAIT)) begin
      err_sp_d = 1'b1;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      beat_q     <= '0;
      lg_q       <= '0;
      gap_q      <= '0;
      err_to_q   <= 1'b0;
      err_sp_q   <= 1'b0;
      s_ready_q  <= 1'b0;
      busy_q     <= 1'b0;
      m_valid_q  <= 1'b0;
      fc_valid_q <= 1'b0;
      fc_d1_q    <= '0;
      fc_d2_q    <= '0;
      fc_d3_q    <= '0;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      lg_q       <= lg_d;
      gap_q      <= gap_d;
      err_to_q   <= err_to_d;
      err_sp_q   <= err_sp_d;
      s_ready_q  <= (state_d == IDLE) || (state_d == FEED);
      busy_q     <= (state_d != IDLE);
      m_valid_q  <= (state_d == DONE);
      fc_valid_q <= accept;
      if (accept) begin
        fc_d1_q <= s_data_1;
        fc_d2_q <= s_data_2;
        fc_d3_q <= s_data_3;
      end
    end
  end

  fc_argmax_tracker #(
    .DATA_W(DATA_W)
  ) u_argmax (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (trk_clear),
    .strobe_i(logit_stb),
    .load_i  (trk_load),
    .idx_i   (lg_q),
    .data_i  (fc_data_out),
    .idx_o   (m_class),
    .val_o   (m_logit)
  );

`ifdef FC_SCORE_BUF_EN
  logic signed [DATA_W-1:0] score_q [OUTPUT_NUM];

  // Per-frame logit store, overwritten entry by entry by the next frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(OUTPUT_NUM); i++) begin
        score_q[i] <= '0;
      end
    end else if (logit_stb) begin
      score_q[lg_q] <= fc_data_out;
    end
  end

  assign rd_data = (32'(rd_idx) < OUTPUT_NUM) ? score_q[rd_idx] : '0;
`else
  logic unused_rd_idx;
  assign unused_rd_idx = ^rd_idx;
  assign rd_data       = '0;
`endif

  assign s_ready      = s_ready_q;
  assign busy         = busy_q;
  assign m_valid      = m_valid_q;
  assign fc_valid_in  = fc_valid_q;
  assign fc_data_1    = fc_d1_q;
  assign fc_data_2    = fc_d2_q;
  assign fc_data_3    = fc_d3_q;
  assign err_timeout  = err_to_q;
  assign err_spurious = err_sp_q;

endmodule

// File: tb/tb_fc_frame_sequencer.sv
// Bench for fc_frame_sequencer: randomized frames checked every cycle
// against a transaction-level model (beat/logit counts, logit queue, argmax).
module tb_fc_frame_sequencer;

  localparam int IW = 16;
  localparam int ON = 10;
  localparam int TO = 64;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              s_valid;
  logic              s_ready;
  logic signed [11:0] s_data_1, s_data_2, s_data_3;
  logic              fc_valid_in;
  logic signed [11:0] fc_data_1, fc_data_2, fc_data_3;
  logic signed [11:0] fc_data_out;
  logic              fc_valid_out;
  logic              m_valid;
  logic              m_ready;
  logic [3:0]        m_class;
  logic signed [11:0] m_logit;
  logic              busy;
  logic              err_timeout;
  logic              err_spurious;
  logic [3:0]        rd_idx;
  logic signed [11:0] rd_data;

  fc_frame_sequencer #(
    .INPUT_WIDTH(IW),
    .OUTPUT_NUM (ON),
    .DATA_W     (12),
    .TIMEOUT_CYC(TO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_data_1    (s_data_1),
    .s_data_2    (s_data_2),
    .s_data_3    (s_data_3),
    .fc_valid_in (fc_valid_in),
    .fc_data_1   (fc_data_1),
    .fc_data_2   (fc_data_2),
    .fc_data_3   (fc_data_3),
    .fc_data_out (fc_data_out),
    .fc_valid_out(fc_valid_out),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_class     (m_class),
    .m_logit     (m_logit),
    .busy        (busy),
    .err_timeout (err_timeout),
    .err_spurious(err_spurious),
    .rd_idx      (rd_idx),
    .rd_data     (rd_data)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state.
  bit e_rdy, e_fvi, e_mv, e_busy, e_to, e_sp;
  int e_d1, e_d2, e_d3, e_cls, e_val;
  int m_beats, m_gap;
  bit m_pend;
  int m_lg[$];

  int lg_tab[ON];
  int gap_tab[ON];

  function automatic void model_reset();
    e_rdy = 0; e_fvi = 0; e_mv = 0; e_busy = 0; e_to = 0; e_sp = 0;
    e_d1 = 0; e_d2 = 0; e_d3 = 0; e_cls = 0; e_val = 0;
    m_beats = 0; m_gap = 0; m_pend = 0;
    m_lg.delete();
  endfunction

  // Advance the model over one clock edge with the current inputs, then
  // compare all outputs on the following falling edge.
  task automatic step();
    bit acc, waiting, pend_old;
    acc      = s_valid && e_rdy;
    pend_old = m_pend;
    waiting  = (m_beats == IW) && !m_pend;
    e_fvi    = acc;
    if (acc) begin
      e_d1 = int'(s_data_1); e_d2 = int'(s_data_2); e_d3 = int'(s_data_3);
      m_beats++;
      if (m_beats == IW) m_gap = 0;
    end
    if (fc_valid_out) begin
      if (waiting) begin
        m_lg.push_back(int'(fc_data_out));
        m_gap = 0;
        if (m_lg.size() == ON) begin
          int best = 0;
          for (int i = 1; i < ON; i++) if (m_lg[i] > m_lg[best]) best = i;
          e_cls  = best;
          e_val  = m_lg[best];
          m_pend = 1;
        end
      end else begin
        e_sp = 1;
      end
    end else if (waiting) begin
      m_gap++;
      if (m_gap >= TO) begin
        e_to = 1;
        m_beats = 0;
        m_lg.delete();
      end
    end
    if (pend_old && m_ready) begin
      m_pend = 0;
      m_beats = 0;
      m_lg.delete();
    end
    e_rdy  = !m_pend && (m_beats < IW);
    e_mv   = m_pend;
    e_busy = (m_beats > 0) || m_pend;

    @(posedge clk);
    @(negedge clk);
    check_eq("s_ready", int'(s_ready), int'(e_rdy));
    check_eq("fc_valid_in", int'(fc_valid_in), int'(e_fvi));
    if (e_fvi) begin
      check_eq("fc_data_1", int'(fc_data_1), e_d1);
      check_eq("fc_data_2", int'(fc_data_2), e_d2);
      check_eq("fc_data_3", int'(fc_data_3), e_d3);
    end
    check_eq("m_valid", int'(m_valid), int'(e_mv));
    if (e_mv) begin
      check_eq("m_class", int'(m_class), e_cls);
      check_eq("m_logit", int'(m_logit), e_val);
    end
    check_eq("busy", int'(busy), int'(e_busy));
    check_eq("err_timeout", int'(err_timeout), int'(e_to));
    check_eq("err_spurious", int'(err_spurious), int'(e_sp));
  endtask

  task automatic check_all_zero();
    check_eq("rst_s_ready", int'(s_ready), 0);
    check_eq("rst_fc_valid_in", int'(fc_valid_in), 0);
    check_eq("rst_fc_data_1", int'(fc_data_1), 0);
    check_eq("rst_fc_data_2", int'(fc_data_2), 0);
    check_eq("rst_fc_data_3", int'(fc_data_3), 0);
    check_eq("rst_m_valid", int'(m_valid), 0);
    check_eq("rst_m_class", int'(m_class), 0);
    check_eq("rst_m_logit", int'(m_logit), 0);
    check_eq("rst_busy", int'(busy), 0);
    check_eq("rst_err_timeout", int'(err_timeout), 0);
    check_eq("rst_err_spurious", int'(err_spurious), 0);
    check_eq("rst_rd_data", int'(rd_data), 0);
  endtask

  task automatic feed_beats(input int target, input int gap_pct);
    int c = 0;
    while (m_beats < target) begin
      s_valid  = (c > 200) || ($urandom_range(99) >= gap_pct);
      s_data_1 = 12'($urandom);
      s_data_2 = 12'($urandom);
      s_data_3 = 12'($urandom);
      step();
      c++;
    end
    s_valid = 1'b0;
  endtask

  // One frame: feed, n_logits logits with gap_tab idle cycles before each,
  // then hold m_ready low for 'hold' cycles (optionally with a stray logit).
  task automatic run_frame(input int gap_pct, input int hold, input bit spur,
                           input int n_logits, input int exp_cls, input int exp_val);
    int pulses = 0;
    int c = 0;
    m_ready = (hold == 0);
    while (m_beats < IW) begin
      s_valid  = (c > 200) || ($urandom_range(99) >= gap_pct);
      s_data_1 = 12'($urandom);
      s_data_2 = 12'($urandom);
      s_data_3 = 12'($urandom);
      step();
      pulses += int'(fc_valid_in);
      c++;
    end
    s_valid = 1'b0;
    check_eq("fvi_pulses", pulses, IW);
    for (int i = 0; i < n_logits; i++) begin
      repeat (gap_tab[i]) step();
      fc_valid_out = 1'b1;
      fc_data_out  = 12'(lg_tab[i]);
      step();
      fc_valid_out = 1'b0;
    end
    if (n_logits < ON) begin
      repeat (TO + 6) step();
    end else begin
      if (exp_cls >= 0) begin
        check_eq("dir_m_class", int'(m_class), exp_cls);
        check_eq("dir_m_logit", int'(m_logit), exp_val);
      end
      for (int h = 0; h < hold; h++) begin
        if (spur && h == hold / 2) begin
          fc_valid_out = 1'b1;
          fc_data_out  = 12'($urandom);
        end
        step();
        fc_valid_out = 1'b0;
      end
      m_ready = 1'b1;
      step();
    end
  endtask

  task automatic rand_tabs(input int max_gap);
    for (int i = 0; i < ON; i++) begin
      lg_tab[i]  = int'($signed(12'($urandom)));
      gap_tab[i] = $urandom_range(max_gap);
    end
  endtask

  initial begin
    int dir_lg[ON] = '{5, -3, 100, 7, 100, 0, -2048, 2047, 1, 2};

    rst_n = 1'b0; s_valid = 1'b0; s_data_1 = '0; s_data_2 = '0; s_data_3 = '0;
    fc_valid_out = 1'b0; fc_data_out = '0; m_ready = 1'b0; rd_idx = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check_all_zero();
    rst_n = 1'b1;
    step();

    // Directed frame, logits at one per cycle.
    for (int i = 0; i < ON; i++) begin lg_tab[i] = dir_lg[i]; gap_tab[i] = 0; end
    gap_tab[0] = 2;
    run_frame(0, 0, 0, ON, 7, 2047);

`ifdef FC_SCORE_BUF_EN
    rd_idx = 4'd2;  #1 check_eq("rd_data_2", int'(rd_data), 100);
    rd_idx = 4'd7;  #1 check_eq("rd_data_7", int'(rd_data), 2047);
    rd_idx = 4'd12; #1 check_eq("rd_data_12", int'(rd_data), 0);
`else
    rd_idx = 4'd2;  #1 check_eq("rd_data_2", int'(rd_data), 0);
    rd_idx = 4'd12; #1 check_eq("rd_data_12", int'(rd_data), 0);
`endif
    rd_idx = '0;

    // All-equal logits: lowest index wins.
    for (int i = 0; i < ON; i++) begin lg_tab[i] = -4; gap_tab[i] = 0; end
    run_frame(0, 0, 0, ON, 0, -4);

    // Random input gaps, 63-cycle stall between logits 4 and 5.
    rand_tabs(3);
    gap_tab[5] = TO - 1;
    run_frame(40, 0, 0, ON, -1, 0);
    check_eq("no_timeout_63", int'(err_timeout), 0);

    // 64-cycle stall after logit 3.
    rand_tabs(3);
    run_frame(20, 0, 0, 4, -1, 0);
    check_eq("timeout_flag", int'(err_timeout), 1);
    check_eq("timeout_idle", int'(busy), 0);

    // Next frame after timeout.
    rand_tabs(2);
    run_frame(30, 0, 0, ON, -1, 0);

    // Result held 20 cycles with a stray logit during DONE.
    rand_tabs(2);
    run_frame(10, 20, 1, ON, -1, 0);
    check_eq("spurious_flag", int'(err_spurious), 1);

    // Back-to-back random frames with m_ready tied high.
    for (int f = 0; f < 4; f++) begin
      rand_tabs(f);
      run_frame($urandom_range(50), 0, 0, ON, -1, 0);
    end

    // Reset after beat 9 of a frame.
    m_ready = 1'b0;
    feed_beats(9, 30);
    rst_n = 1'b0;
    #1;
    check_all_zero();
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // Recovery frame.
    rand_tabs(2);
    run_frame(25, 3, 0, ON, -1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
